// File: rtl/ps2_rx_fifo_pkg.sv
// Shared constants and types for the PS/2 receive path.
package ps2_pkg;

    localparam int PS2_FRAME_BITS      = 11;
    localparam int PS2_DATA_BITS       = 8;
    localparam int PS2_FIFO_DEPTH_DEF  = 8;
    localparam int PS2_TIMEOUT_CYC_DEF = 200000;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY,
        STOP
    } ps2_state_e;

    // PS/2 uses odd parity across the data byte plus the parity bit.
    function automatic logic ps2_odd_ok(input logic [PS2_DATA_BITS-1:0] b, input logic p);
        return ^{b, p};
    endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// Pin and read-side bundle between the PS/2 receiver and its neighbours.
interface ps2_rx_fifo_if;
    import ps2_pkg::*;

    logic                     ps2_clk;
    logic                     ps2_data;
    logic                     rdn;
    logic [PS2_DATA_BITS-1:0] data;
    logic                     ready;
    logic                     overflow;
    logic                     parity_err;

    modport master (
        output ps2_clk, ps2_data, rdn,
        input  data, ready, overflow, parity_err
    );

    modport slave (
        input  ps2_clk, ps2_data, rdn,
        output data, ready, overflow, parity_err
    );

endinterface

// File: rtl/ps2_rx_fifo_byte_fifo.sv
// Byte queue for received scan codes; a write into a full queue succeeds
// only when a pop happens in the same cycle.
module ps2_byte_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = PS2_FIFO_DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      clrn,
    input  logic                      wr_i,
    input  logic [PS2_DATA_BITS-1:0]  wdata_i,
    input  logic                      rd_i,
    output logic [PS2_DATA_BITS-1:0]  rdata_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [AW:0]              count_q;
    logic [PS2_DATA_BITS-1:0] mem_q [DEPTH];
    logic                     wr_ok, rd_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign rd_ok   = rd_i && !empty_o;
    assign wr_ok   = wr_i && (!full_o || rd_ok);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin synchroniser, frame FSM with timeout,
// and a byte FIFO feeding the key-decode stage.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = PS2_FIFO_DEPTH_DEF,
    parameter int TIMEOUT_CYC = PS2_TIMEOUT_CYC_DEF
) (
    input  logic          clk,
    input  logic          clrn,
    ps2_rx_fifo_if.slave  bus
);

    localparam int TW = $clog2(TIMEOUT_CYC);

    logic [2:0]               kclk_q, kdat_q;
    logic                     fall, rx_bit;
    ps2_state_e               state_q;
    logic [2:0]               bitcnt_q;
    logic [PS2_DATA_BITS-1:0] shift_q;
    logic                     par_q;
    logic [TW-1:0]            tmo_q;
    logic                     commit_q, perr_q;
    logic                     ovf_q, ovf_d;
    logic                     pop, fifo_full, fifo_empty;
    logic [PS2_DATA_BITS-1:0] fifo_rdata;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    // Flops reset to 1 so a released reset never looks like a falling edge.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            kclk_q <= 3'b111;
            kdat_q <= 3'b111;
        end else begin
            kclk_q <= {kclk_q[1:0], bus.ps2_clk};
            kdat_q <= {kdat_q[1:0], bus.ps2_data};
        end
    end

    assign fall   = !kclk_q[1] && kclk_q[2];
    assign rx_bit = kdat_q[1];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tmo_q    <= '0;
            commit_q <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            commit_q <= 1'b0;
            perr_q   <= 1'b0;
            if (state_q == IDLE || fall) tmo_q <= '0;
            else                         tmo_q <= tmo_q + TW'(1);

            case (state_q)
                IDLE: if (fall && !rx_bit) begin
                    state_q  <= SHIFT;
                    bitcnt_q <= '0;
                end
                SHIFT: if (fall) begin
                    shift_q  <= {rx_bit, shift_q[PS2_DATA_BITS-1:1]};
                    bitcnt_q <= bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_q <= PARITY;
                end
                PARITY: if (fall) begin
                    par_q   <= rx_bit;
                    state_q <= STOP;
                end
                STOP: if (fall) begin
                    if (rx_bit && ps2_odd_ok(shift_q, par_q)) commit_q <= 1'b1;
                    else                                      perr_q   <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            // A stalled device abandons the frame; any edge this cycle wins.
            if (state_q != IDLE && !fall && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                state_q <= IDLE;
                shift_q <= '0;
                perr_q  <= 1'b1;
            end
        end
    end

    assign pop = !bus.rdn && !fifo_empty;

    ps2_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .clrn    (clrn),
        .wr_i    (commit_q),
        .wdata_i (shift_q),
        .rd_i    (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Setting wins over the pop-driven clear.
    always_comb begin
        ovf_d = ovf_q && !pop;
        if (commit_q && fifo_full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

    assign bus.ready      = (fifo_count != '0);
    assign bus.data       = bus.ready ? fifo_rdata : '0;
    assign bus.overflow   = ovf_q;
    assign bus.parity_err = perr_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: frame driver, queue-based reference model, and a
// monitor that scores every byte the DUT hands over.
module tb_ps2_rx_fifo;
    import ps2_pkg::*;

    localparam int DEPTH = 8;
    localparam int TMO   = 400;
    localparam int HALF  = 20;

    logic clk  = 1'b0;
    logic clrn = 1'b0;
    always #5 clk = ~clk;

    ps2_rx_fifo_if bus();

    ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         exp_perr  = 0;
    int         perr_seen = 0;
    int         ready_rises = 0;
    bit         model_ovf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives bits LSB first, one falling ps2_clk edge per bit.
    task automatic send_bits(input logic [10:0] bits, input int nbits,
                             input bit chk_lat, input logic [7:0] lat_byte);
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_data = bits[i];
            cycles(HALF);
            bus.ps2_clk = 1'b0;
            if (chk_lat && i == nbits - 1) begin
                cycles(3);
                chk("lat_ready_early", 32'(bus.ready), 32'(0));
                cycles(1);
                chk("lat_ready", 32'(bus.ready), 32'(1));
                chk("lat_data", 32'(bus.data), 32'(lat_byte));
                cycles(HALF - 4);
            end else begin
                cycles(HALF);
            end
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
        cycles(HALF);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par,
                              input bit bad_stop, input bit chk_lat);
        logic        p;
        logic [10:0] bits;
        p    = (~^b) ^ bad_par;
        bits = {1'b1 ^ bad_stop, p, b, 1'b0};
        if (bad_par || bad_stop)        exp_perr++;
        else if (exp_q.size() < DEPTH)  exp_q.push_back(b);
        else                            model_ovf = 1'b1;
        send_bits(bits, PS2_FRAME_BITS, chk_lat, b);
    endtask

    task automatic drain();
        int n;
        n = 0;
        if (exp_q.size() > 0) model_ovf = 1'b0;
        bus.rdn = 1'b0;
        while (bus.ready && n < 200) begin
            cycles(1);
            n++;
        end
        bus.rdn = 1'b1;
        if (n >= 200) chk("drain_timeout", 32'(bus.ready), 32'(0));
        cycles(2);
        chk("drain_empty", 32'(exp_q.size()), 32'(0));
        chk("drain_ovf", 32'(bus.overflow), 32'(model_ovf));
    endtask

    // Monitor: scores each handed-over byte and tracks error/ready pulses.
    initial begin
        logic [7:0] e;
        logic perr_prev, ready_prev;
        perr_prev  = 1'b0;
        ready_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!clrn) begin
                perr_prev  = 1'b0;
                ready_prev = 1'b0;
            end else begin
                if (bus.parity_err) begin
                    perr_seen++;
                    if (perr_prev) chk("perr_width", 32'(2), 32'(1));
                end
                perr_prev = bus.parity_err;
                if (bus.ready && !ready_prev) ready_rises++;
                ready_prev = bus.ready;
                if (bus.ready && !bus.rdn) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_byte", 32'(bus.data), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pop_data", 32'(bus.data), 32'(e));
                    end
                end
            end
        end
    end

    initial begin
        int rr;
        logic [7:0] b;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        bus.rdn      = 1'b1;
        clrn         = 1'b0;
        cycles(3);
        chk("rst_ready", 32'(bus.ready), 32'(0));
        chk("rst_data", 32'(bus.data), 32'(0));
        chk("rst_ovf", 32'(bus.overflow), 32'(0));
        chk("rst_perr", 32'(bus.parity_err), 32'(0));
        clrn = 1'b1;
        cycles(5);

        // Good frame with latency and hold, then a single pop
        send_frame(8'h1C, 1'b0, 1'b0, 1'b1);
        cycles(10);
        chk("hold_ready", 32'(bus.ready), 32'(1));
        chk("hold_data", 32'(bus.data), 32'h1C);
        bus.rdn = 1'b0;
        cycles(1);
        bus.rdn = 1'b1;
        chk("pop_ready", 32'(bus.ready), 32'(0));

        // Bad parity
        send_frame(8'h75, 1'b1, 1'b0, 1'b0);
        cycles(5);
        chk("badpar_perr", 32'(perr_seen), 32'(exp_perr));
        chk("badpar_ready", 32'(bus.ready), 32'(0));

        // Overflow
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0);
        cycles(5);
        chk("ovf_set", 32'(bus.overflow), 32'(model_ovf));
        chk("ovf_head", 32'(bus.data), 32'h01);
        bus.rdn = 1'b0;
        cycles(1);
        bus.rdn = 1'b1;
        model_ovf = 1'b0;
        chk("ovf_clr", 32'(bus.overflow), 32'(0));
        chk("ovf_next", 32'(bus.data), 32'h02);
        chk("ovf_ready", 32'(bus.ready), 32'(1));
        drain();

        // Timeout mid-frame, then recovery
        send_bits({7'h7F, 4'b1010}, 5, 1'b0, 8'h00);
        exp_perr++;
        cycles(TMO + 10);
        chk("tmo_perr", 32'(perr_seen), 32'(exp_perr));
        send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
        cycles(5);
        chk("tmo_recover", 32'(bus.data), 32'hE0);
        drain();

        // Streaming with rdn tied low
        rr = ready_rises;
        bus.rdn = 1'b0;
        send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h74, 1'b0, 1'b0, 1'b0);
        cycles(5);
        bus.rdn = 1'b1;
        chk("stream_pulses", 32'(ready_rises - rr), 32'(3));
        chk("stream_empty", 32'(exp_q.size()), 32'(0));

        // Randomized batches in hold or stream mode
        for (int bt = 0; bt < 4; bt++) begin
            bus.rdn = ($urandom_range(0, 1) == 1) ? 1'b0 : 1'b1;
            for (int k = 0; k < int'($urandom_range(3, 10)); k++) begin
                b  = 8'($urandom);
                rr = int'($urandom_range(0, 7));
                send_frame(b, (rr < 2), (rr == 2), 1'b0);
            end
            cycles(5);
            chk("rand_ovf", 32'(bus.overflow), 32'(model_ovf));
            chk("rand_perr", 32'(perr_seen), 32'(exp_perr));
            drain();
        end

        // Async reset mid-frame with bytes queued
        send_frame(8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0);
        send_frame(8'h33, 1'b0, 1'b0, 1'b0);
        send_bits({7'h7F, 4'b0110}, 4, 1'b0, 8'h00);
        #3;
        clrn = 1'b0;
        #1;
        chk("arst_ready", 32'(bus.ready), 32'(0));
        chk("arst_data", 32'(bus.data), 32'(0));
        chk("arst_ovf", 32'(bus.overflow), 32'(0));
        chk("arst_perr", 32'(bus.parity_err), 32'(0));
        exp_q.delete();
        model_ovf = 1'b0;
        cycles(2);
        clrn = 1'b1;
        cycles(5);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        cycles(5);
        chk("arst_after_ready", 32'(bus.ready), 32'(1));
        chk("arst_after_data", 32'(bus.data), 32'hA5);
        drain();
        chk("final_perr", 32'(perr_seen), 32'(exp_perr));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
